svc_rv_mem_arb: RTL and testbench

// - Shares one single-port synchronous memory (1-cycle read latency) between the
//   svc_rv instruction-fetch port and data port.
// - Used for unified-memory builds where IMEM and DMEM live in one BRAM.
// - Grants at most one request per cycle and routes read data back to the issuer.
// - dmem has priority; a streak limit stops ifetch starvation.
//

---
 rtl/svc_rv_pkg.sv | 12 +
 rtl/svc_rv_mem_arb.sv | 101 ++++++++++
 tb/tb_svc_rv_mem_arb.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/svc_rv_pkg.sv
// Shared svc_rv definitions: memory word size and arbiter grant encoding.
package svc_rv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } gnt_sel_e;

endpackage

// File: rtl/svc_rv_mem_arb.sv
// Two-port (ifetch/data) arbiter onto one single-port 1-cycle-latency memory.
// Data side wins contention until its streak hits MAX_STREAK, then ifetch gets one.
module svc_rv_mem_arb
  import svc_rv_pkg::*;
#(
  parameter int AW         = 10,
  parameter int MAX_STREAK = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req_valid,
  output logic            i_req_ready,
  input  logic [AW-1:0]   i_req_addr,
  output logic            i_resp_valid,
  output logic [XLEN-1:0] i_resp_data,
  input  logic            d_req_valid,
  output logic            d_req_ready,
  input  logic            d_req_we,
  input  logic [AW-1:0]   d_req_addr,
  input  logic [XLEN-1:0] d_req_wdata,
  input  logic [3:0]      d_req_wstrb,
  output logic            d_resp_valid,
  output logic [XLEN-1:0] d_resp_data,
  output logic            mem_ren,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  gnt_sel_e      gnt;
  logic [SW-1:0] streak_q, streak_d;
  logic          i_pend_q, i_pend_d;
  logic          d_pend_q, d_pend_d;

  always_comb begin
    gnt = GNT_NONE;
    if (d_req_valid && (!i_req_valid || streak_q < STREAK_MAX)) gnt = GNT_D;
    else if (i_req_valid)                                      gnt = GNT_I;
  end

  assign i_req_ready = (gnt == GNT_I);
  assign d_req_ready = (gnt == GNT_D);

  always_comb begin
    mem_ren   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = i_req_addr;
    mem_wdata = d_req_wdata;
    mem_wstrb = 4'h0;
    case (gnt)
      GNT_I: mem_ren = 1'b1;
      GNT_D: begin
        mem_addr = d_req_addr;
        if (d_req_we) begin
          mem_we    = 1'b1;
          mem_wstrb = d_req_wstrb;
        end else begin
          mem_ren = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Streak only counts while ifetch is actually waiting; saturation is implicit
  // because a contested d grant is impossible once streak reaches the limit.
  always_comb begin
    streak_d = streak_q;
    if (!i_req_valid || gnt == GNT_I) streak_d = '0;
    else if (gnt == GNT_D)            streak_d = streak_q + SW'(1);
  end

  // One-deep response tag: the memory answers every read exactly one cycle later.
  always_comb begin
    i_pend_d = (gnt == GNT_I);
    d_pend_d = (gnt == GNT_D) && !d_req_we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= '0;
      i_pend_q <= 1'b0;
      d_pend_q <= 1'b0;
    end else begin
      streak_q <= streak_d;
      i_pend_q <= i_pend_d;
      d_pend_q <= d_pend_d;
    end
  end

  assign i_resp_valid = i_pend_q;
  assign d_resp_valid = d_pend_q;
  assign i_resp_data  = mem_rdata;
  assign d_resp_data  = mem_rdata;

endmodule

// File: tb/tb_svc_rv_mem_arb.sv
// Vector table plus response scoreboard for svc_rv_mem_arb against a bench BRAM.
module tb_svc_rv_mem_arb;
  import svc_rv_pkg::*;

  localparam int AW = 10;
  localparam int MS = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_req_valid, i_req_ready, i_resp_valid;
  logic [AW-1:0]   i_req_addr;
  logic [31:0]     i_resp_data;
  logic            d_req_valid, d_req_ready, d_req_we, d_resp_valid;
  logic [AW-1:0]   d_req_addr;
  logic [31:0]     d_req_wdata, d_resp_data;
  logic [3:0]      d_req_wstrb;
  logic            mem_ren, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [31:0]     mem_wdata, mem_rdata;
  logic [3:0]      mem_wstrb;

  always #5 clk = ~clk;

  svc_rv_mem_arb #(.AW(AW), .MAX_STREAK(MS)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .mem_ren(mem_ren), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  // Bench BRAM; shadow is the expected image, updated from what the bench drove.
  logic [31:0] mem    [0:(1<<AW)-1];
  logic [31:0] shadow [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= mem[mem_addr];
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  // exp_gnt = {i_req_ready, d_req_ready, mem_ren, mem_we}
  typedef struct {
    logic iv; logic [AW-1:0] ia;
    logic dv; logic dwe; logic [AW-1:0] da; logic [31:0] dwd; logic [3:0] dws;
    logic [3:0] exp_gnt; logic [3:0] exp_wstrb;
  } vec_t;

  typedef struct { logic is_i; logic [31:0] data; } exp_t;

  exp_t sbq[$];
  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic vec_t mk(logic iv, logic [AW-1:0] ia, logic dv, logic dwe,
                              logic [AW-1:0] da, logic [31:0] dwd, logic [3:0] dws,
                              logic [3:0] g);
    vec_t v;
    v.iv = iv; v.ia = ia; v.dv = dv; v.dwe = dwe; v.da = da; v.dwd = dwd; v.dws = dws;
    v.exp_gnt = g;
    v.exp_wstrb = g[0] ? dws : 4'h0;
    return v;
  endfunction

  task automatic drive(vec_t v);
    i_req_valid = v.iv; i_req_addr = v.ia;
    d_req_valid = v.dv; d_req_we = v.dwe; d_req_addr = v.da;
    d_req_wdata = v.dwd; d_req_wstrb = v.dws;
  endtask

  // Drive, then check at the falling edge: responses due now, grant, memory drive.
  task automatic drive_check(vec_t v, int idx);
    exp_t e;
    drive(v);
    @(negedge clk);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check($sformatf("resp_valid[%0d]", idx), {62'd0, i_resp_valid, d_resp_valid},
            e.is_i ? 64'd2 : 64'd1);
      check($sformatf("resp_data[%0d]", idx), {32'd0, e.is_i ? i_resp_data : d_resp_data},
            {32'd0, e.data});
    end else begin
      check($sformatf("no_resp[%0d]", idx), {62'd0, i_resp_valid, d_resp_valid}, 64'd0);
    end
    check($sformatf("one_ready[%0d]", idx), {63'd0, i_req_ready & d_req_ready}, 64'd0);
    check($sformatf("ren_we_excl[%0d]", idx), {63'd0, mem_ren & mem_we}, 64'd0);
    check($sformatf("gnt[%0d]", idx), {60'd0, i_req_ready, d_req_ready, mem_ren, mem_we},
          {60'd0, v.exp_gnt});
    check($sformatf("wstrb[%0d]", idx), {60'd0, mem_wstrb}, {60'd0, v.exp_wstrb});
    if (v.exp_gnt[3]) begin
      check($sformatf("i_addr[%0d]", idx), {54'd0, mem_addr}, {54'd0, v.ia});
      sbq.push_back('{is_i: 1'b1, data: shadow[v.ia]});
    end
    if (v.exp_gnt[2]) begin
      check($sformatf("d_addr[%0d]", idx), {54'd0, mem_addr}, {54'd0, v.da});
      if (v.dwe) begin
        check($sformatf("wdata[%0d]", idx), {32'd0, mem_wdata}, {32'd0, v.dwd});
        for (int b = 0; b < 4; b++)
          if (v.dws[b]) shadow[v.da][8*b +: 8] = v.dwd[8*b +: 8];
      end else begin
        sbq.push_back('{is_i: 1'b0, data: shadow[v.da]});
      end
    end
  endtask

  task automatic cycle(vec_t v, int idx);
    drive_check(v, idx);
    @(posedge clk);
    #1;
  endtask

  localparam logic [3:0] G0 = 4'b0000; // idle
  localparam logic [3:0] GI = 4'b1010; // ifetch read
  localparam logic [3:0] GR = 4'b0110; // data read
  localparam logic [3:0] GW = 4'b0101; // data write

  initial begin
    vec_t idle;
    for (int k = 0; k < (1 << AW); k++) begin
      mem[k]    = 32'hA500_0000 ^ (k * 32'h0001_0203);
      shadow[k] = 32'hA500_0000 ^ (k * 32'h0001_0203);
    end
    mem_rdata = '0;
    idle = mk(0, 0, 0, 0, 0, 0, 0, G0);

    // Reset state
    rst_n = 1'b0;
    drive(idle);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_resp", {62'd0, i_resp_valid, d_resp_valid}, 64'd0);
    check("rst_drive", {57'd0, i_req_ready, d_req_ready, mem_ren, mem_we, mem_wstrb}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    vecs.push_back(idle);
    for (int c = 0; c < 4; c++) vecs.push_back(mk(1, 10'h010, 0, 0, 0, 0, 0, GI));
    // Contention: d,d,d,d,i,d
    for (int c = 0; c < 6; c++)
      vecs.push_back(mk(1, 10'h011, 1, 0, 10'h030, 0, 0, (c == 4) ? GI : GR));
    vecs.push_back(mk(1, 10'h011, 1, 1, 10'h020, 32'hDEADBEEF, 4'h3, GW));
    vecs.push_back(idle);
    vecs.push_back(mk(0, 0, 1, 0, 10'h020, 0, 0, GR));
    vecs.push_back(mk(1, 10'h040, 0, 0, 0, 0, 0, GI));
    vecs.push_back(idle);
    vecs.push_back(mk(0, 0, 1, 1, 10'h021, 32'h1234_5678, 4'hC, GW));
    vecs.push_back(mk(1, 10'h021, 1, 0, 10'h020, 0, 0, GR));
    vecs.push_back(mk(1, 10'h021, 0, 0, 0, 0, 0, GI));
    vecs.push_back(idle);

    foreach (vecs[n]) cycle(vecs[n], n);

    // Reset right after a data read grant: the response must never appear.
    drive_check(mk(0, 0, 1, 0, 10'h005, 0, 0, GR), 100);
    rst_n = 1'b0;
    sbq.delete();
    drive(idle);
    @(posedge clk); #1;
    check("rst_mid_resp", {62'd0, i_resp_valid, d_resp_valid}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) cycle(idle, 101 + n);
    cycle(mk(1, 10'h007, 0, 0, 0, 0, 0, GI), 104);
    cycle(idle, 105);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
